// File: rtl/mem_arbiter_if.sv
// Bundle of fetch, data and memory-side signals shared by mem_arbiter and its environment.
// The slave modport is the arbiter's view; master is the requester/memory side.
`timescale 1ns/1ps
interface mem_arbiter_if;
    logic        i_req;
    logic [15:0] i_addr;
    logic [15:0] i_data;
    logic        i_done;
    logic        i_stall;

    logic        d_rd;
    logic        d_wr;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic [15:0] d_rdata;
    logic        d_done;
    logic        d_stall;

    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_rd;
    logic        mem_wr;
    logic [15:0] mem_rdata;
    logic        mem_done;
    logic        mem_stall;

    logic        err;

    modport slave (
        input  i_req, i_addr, d_rd, d_wr, d_addr, d_wdata,
               mem_rdata, mem_done, mem_stall,
        output i_data, i_done, i_stall, d_rdata, d_done, d_stall,
               mem_addr, mem_wdata, mem_rd, mem_wr, err
    );

    modport master (
        output i_req, i_addr, d_rd, d_wr, d_addr, d_wdata,
               mem_rdata, mem_done, mem_stall,
        input  i_data, i_done, i_stall, d_rdata, d_done, d_stall,
               mem_addr, mem_wdata, mem_rd, mem_wr, err
    );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates one multi-cycle memory port between instruction fetch and data access.
// Data has priority; a starvation counter forces a fetch grant after STARVE_MAX data grants.
`timescale 1ns/1ps
module mem_arbiter #(
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam logic [3:0] LP_STARVE_MAX = 4'(STARVE_MAX);

    state_t      r_state;
    logic        r_owner_d;
    logic        r_op_wr;
    logic [15:0] r_addr;
    logic [15:0] r_wdata;
    logic [3:0]  r_starve;
    logic        r_err;

    state_t      w_state_nxt;
    logic        w_d_req;
    logic        w_grant;
    logic        w_d_win;
    logic [3:0]  w_starve_nxt;
    logic        w_err_set;
    logic        w_mem_rd;
    logic        w_mem_wr;
    logic        w_i_done;
    logic        w_d_done;

    assign w_d_req = bus.d_rd | bus.d_wr;

    always_comb begin
        w_state_nxt  = r_state;
        w_grant      = 1'b0;
        w_d_win      = 1'b0;
        w_starve_nxt = r_starve;
        w_err_set    = 1'b0;
        w_mem_rd     = 1'b0;
        w_mem_wr     = 1'b0;
        w_i_done     = 1'b0;
        w_d_done     = 1'b0;

        case (r_state)
            IDLE: begin
                // Conflicting load+store and stray memory completions are both flagged here
                if ((bus.d_rd & bus.d_wr) | bus.mem_done) begin
                    w_err_set = 1'b1;
                end
                if (w_d_req | bus.i_req) begin
                    w_grant     = 1'b1;
                    w_state_nxt = ISSUE;
                    w_d_win     = w_d_req & ~(bus.i_req & (r_starve == LP_STARVE_MAX));
                    if (w_d_win & bus.i_req) begin
                        w_starve_nxt = (r_starve == LP_STARVE_MAX) ? r_starve
                                                                   : r_starve + 4'd1;
                    end else begin
                        w_starve_nxt = '0;
                    end
                end
            end

            ISSUE: begin
                w_mem_rd = ~r_op_wr;
                w_mem_wr = r_op_wr;
                if (bus.mem_done) begin
                    w_err_set = 1'b1;
                end
                if (!bus.mem_stall) begin
                    w_state_nxt = WAIT;
                end
            end

            WAIT: begin
                if (bus.mem_done) begin
                    w_i_done    = ~r_owner_d;
                    w_d_done    = r_owner_d;
                    w_state_nxt = IDLE;
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_owner_d <= 1'b0;
            r_op_wr   <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_starve  <= '0;
            r_err     <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_starve <= w_starve_nxt;
            if (w_err_set) begin
                r_err <= 1'b1;
            end
            if (w_grant) begin
                r_owner_d <= w_d_win;
                // A simultaneous load+store proceeds as a store
                r_op_wr   <= w_d_win & bus.d_wr;
                r_addr    <= w_d_win ? bus.d_addr : bus.i_addr;
                if (w_d_win) begin
                    r_wdata <= bus.d_wdata;
                end
            end
        end
    end

    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;
    assign bus.mem_rd    = w_mem_rd;
    assign bus.mem_wr    = w_mem_wr;

    assign bus.i_data    = bus.mem_rdata;
    assign bus.d_rdata   = bus.mem_rdata;
    assign bus.i_done    = w_i_done;
    assign bus.d_done    = w_d_done;

    assign bus.i_stall   = bus.i_req & ~w_i_done;
    assign bus.d_stall   = w_d_req & ~w_d_done;

    assign bus.err       = r_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed requests push expected commands/completions,
// a negedge monitor pops and compares them as the arbiter presents them.
`timescale 1ns/1ps
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_arbiter_if bus ();

    mem_arbiter #(.STARVE_MAX(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        is_d;
        logic        chk_data;
        logic [15:0] data;
    } done_t;

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
    } cmd_t;

    done_t exp_done_q[$];
    cmd_t  exp_cmd_q[$];
    int    n_checks = 0;
    int    n_err    = 0;

    int unsigned cfg_stall = 0;
    int unsigned cfg_delay = 0;
    logic [15:0] mem_img [logic [15:0]];
    int          last_cmd_len = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    task automatic fail(input string name);
        n_checks++;
        n_err++;
        $display("FAIL %s", name);
    endtask

    task automatic exp_rd(input logic is_d, input logic [15:0] a, input logic [15:0] d);
        cmd_t  c;
        done_t r;
        c.wr = 1'b0; c.addr = a; c.wdata = 16'h0000;
        r.is_d = is_d; r.chk_data = 1'b1; r.data = d;
        exp_cmd_q.push_back(c);
        exp_done_q.push_back(r);
    endtask

    task automatic exp_wr(input logic [15:0] a, input logic [15:0] w);
        cmd_t  c;
        done_t r;
        c.wr = 1'b1; c.addr = a; c.wdata = w;
        r.is_d = 1'b1; r.chk_data = 1'b0; r.data = 16'h0000;
        exp_cmd_q.push_back(c);
        exp_done_q.push_back(r);
    endtask

    // Memory model: stalls cfg_stall cycles, completes cfg_delay cycles after acceptance.
    // Unwritten addresses read back as ~addr.
    logic        rsp_in_cmd = 1'b0;
    logic        rsp_armed  = 1'b0;
    logic        rsp_wr;
    logic [15:0] rsp_addr;
    int unsigned rsp_stall_left = 0;
    int unsigned rsp_wait_left  = 0;

    initial begin
        bus.mem_stall = 1'b0;
        bus.mem_done  = 1'b0;
        bus.mem_rdata = 16'h0000;
        forever begin
            @(posedge clk);
            #1;
            bus.mem_done  = 1'b0;
            bus.mem_stall = 1'b0;
            if (bus.mem_rd || bus.mem_wr) begin
                if (!rsp_in_cmd) begin
                    rsp_in_cmd     = 1'b1;
                    rsp_stall_left = cfg_stall;
                end
                if (rsp_stall_left > 0) begin
                    bus.mem_stall  = 1'b1;
                    rsp_stall_left = rsp_stall_left - 1;
                end else begin
                    rsp_in_cmd    = 1'b0;
                    rsp_armed     = 1'b1;
                    rsp_wait_left = cfg_delay;
                    rsp_wr        = bus.mem_wr;
                    rsp_addr      = bus.mem_addr;
                    if (bus.mem_wr) mem_img[bus.mem_addr] = bus.mem_wdata;
                end
            end else if (rsp_armed) begin
                if (rsp_wait_left == 0) begin
                    bus.mem_done = 1'b1;
                    if (rsp_wr)                        bus.mem_rdata = 16'h0000;
                    else if (mem_img.exists(rsp_addr)) bus.mem_rdata = mem_img[rsp_addr];
                    else                               bus.mem_rdata = ~rsp_addr;
                    rsp_armed = 1'b0;
                end else begin
                    rsp_wait_left = rsp_wait_left - 1;
                end
            end
        end
    end

    logic  mon_cmd_prev = 1'b0;
    logic  mon_cmd_now;
    cmd_t  mon_cmd;
    cmd_t  mon_held;
    done_t mon_done;
    int    mon_cmd_len = 0;

    always @(negedge clk) begin
        if (rst) begin
            mon_cmd_prev = 1'b0;
            mon_cmd_len  = 0;
        end else begin
            chk("i_stall", bus.i_stall, bus.i_req & ~bus.i_done);
            chk("d_stall", bus.d_stall, (bus.d_rd | bus.d_wr) & ~bus.d_done);
            if (bus.i_done || bus.d_done) begin
                chk("done_exclusive", bus.i_done & bus.d_done, 0);
                if (exp_done_q.size() == 0) begin
                    fail("done_unexpected");
                end else begin
                    mon_done = exp_done_q.pop_front();
                    chk("done_owner_d", bus.d_done, mon_done.is_d);
                    if (mon_done.chk_data)
                        chk("done_data", mon_done.is_d ? bus.d_rdata : bus.i_data, mon_done.data);
                end
            end
            mon_cmd_now = bus.mem_rd | bus.mem_wr;
            if (mon_cmd_now && !mon_cmd_prev) begin
                chk("cmd_rd_wr_excl", bus.mem_rd & bus.mem_wr, 0);
                if (exp_cmd_q.size() == 0) begin
                    fail("cmd_unexpected");
                end else begin
                    mon_cmd = exp_cmd_q.pop_front();
                    chk("cmd_wr", bus.mem_wr, mon_cmd.wr);
                    chk("cmd_addr", bus.mem_addr, mon_cmd.addr);
                    if (mon_cmd.wr) chk("cmd_wdata", bus.mem_wdata, mon_cmd.wdata);
                end
                mon_held.wr    = bus.mem_wr;
                mon_held.addr  = bus.mem_addr;
                mon_held.wdata = bus.mem_wdata;
                mon_cmd_len    = 1;
            end else if (mon_cmd_now) begin
                chk("cmd_stable", {bus.mem_wr, bus.mem_addr, bus.mem_wdata},
                    {mon_held.wr, mon_held.addr, mon_held.wdata});
                mon_cmd_len++;
            end else if (mon_cmd_prev) begin
                last_cmd_len = mon_cmd_len;
                mon_cmd_len  = 0;
            end
            mon_cmd_prev = mon_cmd_now;
        end
    end

    task automatic wait_i_done();
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (bus.i_done) return;
        end
        fail("timeout_i_done");
    endtask

    task automatic wait_d_done();
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (bus.d_done) return;
        end
        fail("timeout_d_done");
    endtask

    task automatic do_fetch(input logic [15:0] a);
        bus.i_addr = a;
        bus.i_req  = 1'b1;
        wait_i_done();
        @(posedge clk); #1;
        bus.i_req  = 1'b0;
    endtask

    task automatic do_store(input logic [15:0] a, input logic [15:0] w);
        bus.d_addr  = a;
        bus.d_wdata = w;
        bus.d_wr    = 1'b1;
        wait_d_done();
        @(posedge clk); #1;
        bus.d_wr    = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b1;
        bus.i_req   = 1'b0;
        bus.i_addr  = 16'h0000;
        bus.d_rd    = 1'b0;
        bus.d_wr    = 1'b0;
        bus.d_addr  = 16'h0000;
        bus.d_wdata = 16'h0000;
        mem_img[16'h0010] = 16'hD123;

        // Reset values, and stall outputs following requests during reset
        @(posedge clk); #1;
        bus.i_req = 1'b1;
        @(negedge clk);
        chk("rst_mem_rd", bus.mem_rd, 0);
        chk("rst_mem_wr", bus.mem_wr, 0);
        chk("rst_i_done", bus.i_done, 0);
        chk("rst_d_done", bus.d_done, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_mem_addr", bus.mem_addr, 16'h0000);
        chk("rst_mem_wdata", bus.mem_wdata, 16'h0000);
        chk("rst_i_stall", bus.i_stall, 1);
        @(posedge clk); #1;
        bus.i_req = 1'b0;
        bus.d_wr  = 1'b1;
        @(negedge clk);
        chk("rst_i_stall_low", bus.i_stall, 0);
        chk("rst_d_stall", bus.d_stall, 1);
        @(posedge clk); #1;
        bus.d_wr = 1'b0;
        rst      = 1'b0;

        // Single fetch, minimum latency
        exp_rd(1'b0, 16'h0010, 16'hD123);
        @(posedge clk); #1;
        bus.i_addr = 16'h0010;
        bus.i_req  = 1'b1;
        @(negedge clk);
        chk("t1_c0_i_stall", bus.i_stall, 1);
        chk("t1_c0_no_cmd", bus.mem_rd, 0);
        @(negedge clk);
        chk("t1_c1_mem_rd", bus.mem_rd, 1);
        chk("t1_c1_mem_addr", bus.mem_addr, 16'h0010);
        chk("t1_c1_i_stall", bus.i_stall, 1);
        @(negedge clk);
        chk("t1_c2_i_done", bus.i_done, 1);
        chk("t1_c2_i_data", bus.i_data, 16'hD123);
        chk("t1_c2_mem_rd", bus.mem_rd, 0);
        @(posedge clk); #1;
        bus.i_req = 1'b0;
        @(negedge clk);
        chk("t1_c3_i_done", bus.i_done, 0);

        // Store and fetch together: store first
        exp_wr(16'h0200, 16'hBEEF);
        exp_rd(1'b0, 16'h0300, 16'hFCFF);
        @(posedge clk); #1;
        fork
            do_store(16'h0200, 16'hBEEF);
            do_fetch(16'h0300);
        join

        // Starvation: D,D,D,I,D,D,D,I
        exp_rd(1'b1, 16'h0600, 16'hF9FF);
        exp_rd(1'b1, 16'h0602, 16'hF9FD);
        exp_rd(1'b1, 16'h0604, 16'hF9FB);
        exp_rd(1'b0, 16'h0100, 16'hFEFF);
        exp_rd(1'b1, 16'h0606, 16'hF9F9);
        exp_rd(1'b1, 16'h0608, 16'hF9F7);
        exp_rd(1'b1, 16'h060A, 16'hF9F5);
        exp_rd(1'b0, 16'h0104, 16'hFEFB);
        @(posedge clk); #1;
        fork
            begin
                bus.i_addr = 16'h0100;
                bus.i_req  = 1'b1;
                wait_i_done();
                @(posedge clk); #1;
                bus.i_addr = 16'h0104;
                wait_i_done();
                @(posedge clk); #1;
                bus.i_req  = 1'b0;
            end
            begin
                bus.d_addr = 16'h0600;
                bus.d_rd   = 1'b1;
                for (int k = 1; k <= 6; k++) begin
                    wait_d_done();
                    @(posedge clk); #1;
                    bus.d_addr = 16'h0600 + 16'(2 * k);
                end
                bus.d_rd = 1'b0;
            end
        join

        // Memory stalls 2 cycles in ISSUE, then one extra WAIT cycle
        cfg_stall = 2;
        cfg_delay = 1;
        exp_rd(1'b0, 16'h0040, 16'hFFBF);
        @(posedge clk); #1;
        do_fetch(16'h0040);
        chk("t4_cmd_len", last_cmd_len, 3);
        cfg_stall = 0;
        cfg_delay = 0;

        // Load and store together: error, proceeds as store
        chk("t5_err_before", bus.err, 0);
        exp_wr(16'h0500, 16'h1234);
        @(posedge clk); #1;
        bus.d_addr  = 16'h0500;
        bus.d_wdata = 16'h1234;
        bus.d_rd    = 1'b1;
        bus.d_wr    = 1'b1;
        @(negedge clk);
        chk("t5_c0_err", bus.err, 0);
        @(negedge clk);
        chk("t5_c1_err", bus.err, 1);
        chk("t5_c1_mem_wr", bus.mem_wr, 1);
        wait_d_done();
        @(posedge clk); #1;
        bus.d_rd = 1'b0;
        bus.d_wr = 1'b0;
        exp_rd(1'b0, 16'h0500, 16'h1234);
        do_fetch(16'h0500);
        chk("t5_err_sticky", bus.err, 1);

        // Reset in WAIT of a load; late mem_done lands in IDLE
        cfg_delay = 3;
        begin
            cmd_t c;
            c.wr = 1'b0; c.addr = 16'h0700; c.wdata = 16'h0000;
            exp_cmd_q.push_back(c);
        end
        @(posedge clk); #1;
        bus.d_addr = 16'h0700;
        bus.d_rd   = 1'b1;
        begin
            int n;
            for (n = 0; n < 20; n++) begin
                @(negedge clk);
                if (bus.mem_rd) break;
            end
            if (n == 20) fail("timeout_t6_cmd");
        end
        @(posedge clk); #1;
        rst      = 1'b1;
        bus.d_rd = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("t6_mem_rd", bus.mem_rd, 0);
        chk("t6_mem_wr", bus.mem_wr, 0);
        chk("t6_err_cleared", bus.err, 0);
        chk("t6_d_done", bus.d_done, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("t6_stray_done_err", bus.err, 1);
        cfg_delay = 0;
        exp_rd(1'b0, 16'h0010, 16'hD123);
        @(posedge clk); #1;
        do_fetch(16'h0010);
        chk("t6_err_sticky", bus.err, 1);

        for (int n = 0; n < 50; n++) begin
            if (exp_done_q.size() == 0 && exp_cmd_q.size() == 0) break;
            @(negedge clk);
        end
        chk("drain_done_q", exp_done_q.size(), 0);
        chk("drain_cmd_q", exp_cmd_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one single-ported, multi-cycle unified memory between the fetch stage (instruction reads) and the memory stage (data loads/stores) of the 16-bit processor. It latches the winning request, drives the memory command with a stall/done handshake, and returns read data and a one-cycle done pulse to the owner. It also stalls the losing requester. Data accesses have priority, and a starvation limit guarantees forward progress for fetch.

## Interface
- STARVE_MAX, 3, consecutive data grants allowed while an instruction request waits (legal 1..15)
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- i_req  in  1  fetch read request, level, held until i_done
- i_addr  in  16  fetch address
- i_data  out  16  instruction read data, valid when i_done=1
- i_done  out  1  one-cycle completion pulse to fetch
- i_stall  out  1  fetch must hold (i_req & ~i_done)
- d_rd  in  1  data load request, level, held until d_done
- d_wr  in  1  data store request, level, held until d_done
- d_addr  in  16  data address
- d_wdata  in  16  store data
- d_rdata  out  16  load data, valid when d_done=1
- d_done  out  1  one-cycle completion pulse to memory stage
- d_stall  out  1  memory stage must hold ((d_rd|d_wr) & ~d_done)
- mem_addr  out  16  latched address to memory
- mem_wdata  out  16  latched store data
- mem_rd  out  1  memory read command
- mem_wr  out  1  memory write command
- mem_rdata  in  16  memory read data, valid with mem_done
- mem_done  in  1  memory completion pulse
- mem_stall  in  1  memory cannot accept command this cycle
- err  out  1  sticky protocol error

## Operation
- States: IDLE, ISSUE, WAIT. Registers: owner (I/D), op (rd/wr), addr, wdata, starve counter (4 bits), err.
- IDLE: if no request, stay. Otherwise select winner, latch addr/wdata/op/owner, go to ISSUE.
- Selection: data wins if d_rd|d_wr, unless starve counter == STARVE_MAX and i_req=1, in which case fetch wins. Fetch wins if only i_req.
- Starve counter: +1 on a data grant while i_req=1, saturating at STARVE_MAX. Cleared on any instruction grant, and on a data grant with i_req=0.
- ISSUE: mem_rd/mem_wr asserted per latched op with mem_addr/mem_wdata. If mem_stall=1, stay with command held stable. If mem_stall=0, command accepted; go to WAIT.
- WAIT: command deasserted. On mem_done, pulse the owner's done combinationally in the same cycle. Owner read data = mem_rdata. Go to IDLE.
- Stores pulse d_done on mem_done. d_rdata is don't-care for stores.
- Non-owner done outputs stay 0. i_data and d_rdata carry mem_rdata in every cycle; they are only meaningful with done.
- err set (sticky until rst) when d_rd & d_wr both sampled in IDLE; the access proceeds as a write. err also set by mem_done in IDLE or ISSUE; that mem_done is otherwise ignored.
- Requester inputs are sampled only in IDLE. Changes after the grant have no effect on the in-flight access.

## Timing
- Reset values: state IDLE, owner I, counter 0, err 0. mem_rd/mem_wr/i_done/d_done 0. mem_addr/mem_wdata 0.
- Stall outputs are combinational from requests and dones, so they follow inputs during reset.
- Minimum latency: request sampled in IDLE at cycle 0; command in cycle 1; WAIT cycle 2, where the earliest mem_done gives done in cycle 2; IDLE in cycle 3.
- Peak throughput is one access per 3 cycles. A pending request is sampled in the IDLE cycle immediately after completion.
- Each cycle of mem_stall in ISSUE adds one cycle. Each cycle without mem_done in WAIT adds one cycle.
- Simultaneous mem_done and new requests: the new requests are arbitrated only in the following IDLE cycle.
- rst mid-access (ISSUE or WAIT): next cycle returns to IDLE with the command dropped and no done pulse. A later stray mem_done in IDLE sets err.

## Test plan
- Single fetch at i_addr=0x0010, mem_done 1 cycle after accept with mem_rdata=0xD123 -> mem_rd in cycle 1, i_done with i_data=0xD123 in cycle 2, i_stall 1 in cycles 0-1.
- i_req and d_wr (addr 0x0200, data 0xBEEF) raised together -> store issued first (mem_wr, 0x0200, 0xBEEF), d_done, then fetch issued; i_stall stays high until its own i_done.
- i_req held, d_rd re-asserted every IDLE, STARVE_MAX=3 -> grant order D,D,D,I,D,D,D,I; counter returns to 0 after each I grant.
- mem_stall=1 for 2 cycles in ISSUE -> mem_rd and mem_addr held stable for 3 cycles; WAIT entered only after mem_stall=0.
- d_rd=d_wr=1 in IDLE -> err=1 from next cycle, write issued; err stays 1 until rst.
- rst asserted in WAIT for a load -> no d_done; state IDLE and mem_rd/mem_wr 0 the cycle after; mem_done arriving after reset deasserts -> err=1.
